// File: rtl/mult_seq_unit.sv
// -----------------------------------------------------------------------------
// mult_seq_unit
//
// Iterative shift-add multiplier for the EX stage. Computes the 2*WIDTH-bit
// product of two WIDTH-bit operands, signed or unsigned, one multiplier bit
// per cycle. Signed operands are reduced to magnitudes, multiplied unsigned,
// and the sign is reapplied when the product is written out.
//
// Ports:
//   CLK           rising-edge clock
//   reset         synchronous reset, active-high
//   start         request a new multiply (honoured only in IDLE or DONE)
//   is_signed     1 = two's-complement operands, 0 = unsigned
//   srcA          multiplicand, sampled with an accepted start
//   srcB          multiplier, sampled with an accepted start
//   busy          high while an iteration sequence is in progress
//   stall         hold request to the upstream pipeline registers
//   mult_finishE  one-cycle pulse marking the cycle the product is ready
//   mult_resultE  product; held until overwritten by the next completion
// -----------------------------------------------------------------------------
module mult_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6      // 2**CNT_W must exceed WIDTH
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    output logic               busy,
    output logic               stall,
    output logic               mult_finishE,
    output logic [2*WIDTH-1:0] mult_resultE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;
    logic               finish_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_d;
    logic               accept;
    logic               last_iter;

    assign accept    = start & (state_q != S_BUSY);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        mag_a  = srcA;
        mag_b  = srcB;
        addend = '0;
        // Magnitude of the most negative value (2**(WIDTH-1)) still fits
        // exactly in WIDTH unsigned bits, so no widening is needed here.
        if (is_signed && srcA[WIDTH-1]) mag_a = ~srcA + WIDTH'(1);
        if (is_signed && srcB[WIDTH-1]) mag_b = ~srcB + WIDTH'(1);
        if (mplier_q[0]) addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        acc_d = acc_q + addend;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            finish_q <= 1'b0;
            result_q <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        neg_q    <= is_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        // Final partial product is folded in here, so the
                        // result uses acc_d rather than the stale acc_q.
                        state_q  <= S_DONE;
                        finish_q <= 1'b1;
                        result_q <= neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state_q == S_BUSY);
    assign stall        = accept | busy;
    assign mult_finishE = finish_q;
    assign mult_resultE = result_q;

endmodule

// File: tb/tb_mult_seq_unit.sv
module tb_mult_seq_unit;

    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   srcA;
    logic [W-1:0]   srcB;
    logic           busy;
    logic           stall;
    logic           mult_finishE;
    logic [2*W-1:0] mult_resultE;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected products in acceptance order.
    logic [2*W-1:0] exp_q[$];

    mult_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .srcA         (srcA),
        .srcB         (srcB),
        .busy         (busy),
        .stall        (stall),
        .mult_finishE (mult_finishE),
        .mult_resultE (mult_resultE)
    );

    always #5 CLK = ~CLK;

    // Reference product: sign/zero-extend to 2*W bits and multiply; the
    // low 2*W bits are the correct two's-complement product either way.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
        logic [2*W-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Drive start for one edge from IDLE/DONE, record the expected product,
    // then scramble the operand inputs. Returns at the negedge of cycle 1.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
        @(negedge CLK);
        start = 1'b1; srcA = a; srcB = b; is_signed = s;
        @(posedge CLK);
        exp_q.push_back(model(a, b, s));
        @(negedge CLK);
        start = 1'b0; srcA = $urandom; srcB = $urandom; is_signed = $urandom_range(0, 1);
    endtask

    // Called at the negedge of cycle 1 after acceptance. Steps until the
    // finish pulse (bounded), tallying busy/stall cycles before it. At cycle
    // pulse_at a start with different operands is driven for one cycle.
    task automatic wait_finish(input int pulse_at, output int cyc,
                               output int busy_cnt, output int stall_cnt);
        cyc = 1; busy_cnt = 0; stall_cnt = 0;
        while (mult_finishE !== 1'b1 && cyc < 100) begin
            busy_cnt  += int'(busy === 1'b1);
            stall_cnt += int'(stall === 1'b1);
            if (cyc == pulse_at) begin
                start = 1'b1; srcA = 32'h0000_1234; srcB = 32'h0000_0777; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; srcA = '0; srcB = '0;
        repeat (2) @(negedge CLK);
        total++;
        if (busy !== 1'b0 || mult_finishE !== 1'b0 || mult_resultE !== '0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b fin=%b res=%h stall=%b want 0 0 0 0",
                     busy, mult_finishE, mult_resultE, stall);
        end
        // start during reset: stall follows start combinationally, but reset wins.
        start = 1'b1; srcA = 32'd9; srcB = 32'd9;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL reset_start_stall: got %b want 1", stall);
        end
        @(negedge CLK);
        start = 1'b0; reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_wins: busy got %b want 0", busy);
        end
        @(negedge CLK);
    endtask

    task automatic test_unsigned();
        int cyc, bc, sc;
        logic [2*W-1:0] exp, got;
        @(negedge CLK);
        start = 1'b1; srcA = 32'd3; srcB = 32'd5; is_signed = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL u_cycle0: stall=%b busy=%b want 1 0", stall, busy);
        end
        @(posedge CLK);
        exp_q.push_back(model(32'd3, 32'd5, 1'b0));
        @(negedge CLK);
        start = 1'b0; srcA = 32'hFFFF_FFFF; srcB = 32'hFFFF_FFFF;
        wait_finish(0, cyc, bc, sc);
        total++;
        if (cyc !== 33 || bc !== 32) begin
            bad++; $display("FAIL u_latency: finish at %0d busy cycles %0d want 33 32", cyc, bc);
        end
        got = mult_resultE; exp = exp_q.pop_front();
        total++;
        if (got !== exp || exp !== 64'h0000_0000_0000_000F) begin
            bad++; $display("FAIL u_3x5: got %h want %h", got, exp);
        end
        total++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL u_done_flags: busy=%b stall=%b want 0 0", busy, stall);
        end
        @(negedge CLK);
        total++;
        if (mult_finishE !== 1'b0 || mult_resultE !== 64'hF) begin
            bad++; $display("FAIL u_hold: fin=%b res=%h want 0 %h", mult_finishE, mult_resultE, 64'hF);
        end
    endtask

    task automatic test_table();
        logic [W-1:0] ta[5];
        logic [W-1:0] tb[5];
        logic         ts[5];
        int cyc, bc, sc;
        logic [2*W-1:0] exp, got;
        ta = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tb = '{32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        ts = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            launch(ta[i], tb[i], ts[i]);
            wait_finish(0, cyc, bc, sc);
            total++;
            if (cyc !== 33) begin
                bad++; $display("FAIL tbl%0d_latency: got %0d want 33", i, cyc);
            end
            got = mult_resultE; exp = exp_q.pop_front();
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL tbl%0d_result: got %h want %h", i, got, exp);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, sc;
        logic [2*W-1:0] exp, got;
        @(negedge CLK);
        start = 1'b1; srcA = 32'h0001_0003; srcB = 32'h0000_0101; is_signed = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL ign_stall0: got %b want 1", stall);
        end
        @(posedge CLK);
        exp_q.push_back(model(32'h0001_0003, 32'h0000_0101, 1'b0));
        @(negedge CLK);
        start = 1'b0;
        wait_finish(12, cyc, bc, sc);
        total++;
        if (cyc !== 33 || sc !== 32) begin
            bad++; $display("FAIL ign_timing: finish %0d stall cycles %0d want 33 32", cyc, sc);
        end
        got = mult_resultE; exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++; $display("FAIL ign_result: got %h want %h", got, exp);
        end
        @(negedge CLK);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ign_no_restart: busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, sc;
        logic [2*W-1:0] exp, got;
        launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_finish(0, cyc, bc, sc);
        got = mult_resultE; exp = exp_q.pop_front();
        total++;
        if (cyc !== 33 || got !== exp) begin
            bad++; $display("FAIL b2b_first: cyc %0d res %h want 33 %h", cyc, got, exp);
        end
        // Still in DONE: raise start with the next operands.
        start = 1'b1; srcA = 32'd7; srcB = 32'd6; is_signed = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL b2b_stall: got %b want 1", stall);
        end
        @(posedge CLK);
        exp_q.push_back(model(32'd7, 32'd6, 1'b0));
        @(negedge CLK);
        start = 1'b0; srcA = '0; srcB = '0;
        total++;
        if (busy !== 1'b1 || mult_finishE !== 1'b0 || mult_resultE !== exp) begin
            bad++; $display("FAIL b2b_reenter: busy=%b fin=%b res=%h want 1 0 %h",
                            busy, mult_finishE, mult_resultE, exp);
        end
        wait_finish(0, cyc, bc, sc);
        got = mult_resultE; exp = exp_q.pop_front();
        total++;
        if (cyc !== 33 || got !== exp || exp !== 64'h2A) begin
            bad++; $display("FAIL b2b_second: cyc %0d res %h want 33 %h", cyc, got, exp);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_busy();
        int cyc, bc, sc, fin_seen;
        logic [2*W-1:0] exp, got;
        launch(32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        repeat (9) @(negedge CLK);       // now at BUSY cycle 10
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        void'(exp_q.pop_back());          // aborted op never completes
        total++;
        if (busy !== 1'b0 || mult_resultE !== '0 || mult_finishE !== 1'b0) begin
            bad++; $display("FAIL rst_busy: busy=%b res=%h fin=%b want 0 0 0",
                            busy, mult_resultE, mult_finishE);
        end
        fin_seen = 0;
        for (int i = 0; i < 40; i++) begin
            fin_seen += int'(mult_finishE === 1'b1);
            @(negedge CLK);
        end
        total++;
        if (fin_seen !== 0) begin
            bad++; $display("FAIL rst_no_finish: pulses %0d want 0", fin_seen);
        end
        launch(32'd2, 32'd2, 1'b0);
        wait_finish(0, cyc, bc, sc);
        got = mult_resultE; exp = exp_q.pop_front();
        total++;
        if (cyc !== 33 || got !== exp || exp !== 64'h4) begin
            bad++; $display("FAIL rst_then_2x2: cyc %0d res %h want 33 %h", cyc, got, exp);
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_table();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_busy();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
